// File: rtl/change_dispenser_pkg.sv
// Shared constants and state encoding for the change dispenser and any
// later coin-handling stages that need the same coin values.
package change_dispenser_pkg;

  localparam int PRICE    = 40;
  localparam int CREDIT_W = 6;
  localparam int COIN_W   = 5;
  localparam int CNT_W    = 4;

  localparam logic [COIN_W-1:0] COIN_20 = 5'd20;
  localparam logic [COIN_W-1:0] COIN_10 = 5'd10;
  localparam logic [COIN_W-1:0] COIN_5  = 5'd5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    OFFER = 3'd2,
    DONE  = 3'd3
  } state_t;

endpackage

// File: rtl/change_coin_select.sv
// Greedy coin selector: largest coin not exceeding the remaining amount.
// Amounts below the smallest coin still report the 5 coin; the caller
// decides whether a coin is actually offered.
module change_coin_select
  import change_dispenser_pkg::*;
#(
  parameter int REM_W = change_dispenser_pkg::CREDIT_W,
  parameter int VAL_W = change_dispenser_pkg::COIN_W
) (
  input  logic [REM_W-1:0] rem,
  output logic [VAL_W-1:0] coin
);

  // Pick 20, then 10, then 5.
  always_comb begin
    if (rem >= REM_W'(COIN_20)) begin
      coin = VAL_W'(COIN_20);
    end else if (rem >= REM_W'(COIN_10)) begin
      coin = VAL_W'(COIN_10);
    end else begin
      coin = VAL_W'(COIN_5);
    end
  end

endmodule

// File: rtl/change_en_reg.sv
// Plain enable register with asynchronous active-low clear, used for the
// captured-credit and remaining-change datapath registers.
module change_en_reg #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: captures credit on a sale, works out change or a full
// refund, and pays it out one coin per valid/ack handshake.
//
//   state | meaning
//   IDLE  | waiting for sold; flags and count from last payout readable
//   CALC  | derive remaining amount from captured credit, set refund
//   OFFER | coin offered on coin_out/coin_valid until acked
//   DONE  | one-cycle done pulse, latch short from leftover residue
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int PRICE    = change_dispenser_pkg::PRICE,
  parameter int CREDIT_W = change_dispenser_pkg::CREDIT_W,
  parameter int COIN_W   = change_dispenser_pkg::COIN_W,
  parameter int CNT_W    = change_dispenser_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sold,
  input  logic [CREDIT_W-1:0] credit,
  output logic [COIN_W-1:0]   coin_out,
  output logic                coin_valid,
  input  logic                coin_ack,
  output logic                busy,
  output logic                done,
  output logic                refund,
  output logic                short,
  output logic [CNT_W-1:0]    coin_count
);

  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] MIN_COIN = CREDIT_W'(COIN_5);
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

  state_t              state_q, state_d;
  logic                refund_q, refund_d;
  logic                short_q, short_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cap_en, rem_en;
  logic [CREDIT_W-1:0] cap_q, rem_q, rem_d;
  logic [COIN_W-1:0]   coin_sel;

  change_en_reg #(.W(CREDIT_W)) u_cap (
    .clk   (clk),
    .rst_n (reset),
    .en    (cap_en),
    .d     (credit),
    .q     (cap_q)
  );

  change_en_reg #(.W(CREDIT_W)) u_rem (
    .clk   (clk),
    .rst_n (reset),
    .en    (rem_en),
    .d     (rem_d),
    .q     (rem_q)
  );

  change_coin_select #(.REM_W(CREDIT_W), .VAL_W(COIN_W)) u_sel (
    .rem  (rem_q),
    .coin (coin_sel)
  );

  // Next-state, datapath enables and flag updates.
  always_comb begin
    state_d  = state_q;
    refund_d = refund_q;
    short_d  = short_q;
    cnt_d    = cnt_q;
    cap_en   = 1'b0;
    rem_en   = 1'b0;
    rem_d    = rem_q;
    case (state_q)
      IDLE: begin
        if (sold) begin
          cap_en   = 1'b1;
          refund_d = 1'b0;
          short_d  = 1'b0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        rem_en = 1'b1;
        if (cap_q >= PRICE_C) begin
          rem_d    = cap_q - PRICE_C;
          refund_d = 1'b0;
        end else begin
          rem_d    = cap_q;
          refund_d = 1'b1;
        end
        state_d = (rem_d >= MIN_COIN) ? OFFER : DONE;
      end
      OFFER: begin
        if (coin_ack) begin
          rem_en  = 1'b1;
          rem_d   = rem_q - CREDIT_W'(coin_sel);
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          state_d = (rem_d >= MIN_COIN) ? OFFER : DONE;
        end
      end
      DONE: begin
        short_d = (rem_q != '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and held flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      refund_q <= 1'b0;
      short_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      refund_q <= refund_d;
      short_q  <= short_d;
      cnt_q    <= cnt_d;
    end
  end

  assign coin_valid = (state_q == OFFER);
  assign coin_out   = coin_valid ? coin_sel : '0;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign refund     = refund_q;
  assign short      = short_q;
  assign coin_count = cnt_q;

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sold = 1'b0;
  logic       coin_ack = 1'b0;
  logic [5:0] credit = '0;
  logic [4:0] coin_out;
  logic       coin_valid, busy, done, refund, short;
  logic [3:0] coin_count;

  int checks = 0;
  int errors = 0;

  int obs_coins[$];
  int obs_offers[$];
  int obs_wait, obs_done, obs_bad, obs_done_after;
  int exp_coins[$];
  bit exp_refund, exp_short;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk        (clk),
    .reset      (reset),
    .sold       (sold),
    .credit     (credit),
    .coin_out   (coin_out),
    .coin_valid (coin_valid),
    .coin_ack   (coin_ack),
    .busy       (busy),
    .done       (done),
    .refund     (refund),
    .short      (short),
    .coin_count (coin_count)
  );

  // Reference: change by plain division into 20/10/5 counts.
  task automatic model(input int c);
    int r, n20, n10, n5;
    exp_coins.delete();
    exp_refund = (c < 40);
    r   = exp_refund ? c : c - 40;
    n20 = r / 20; r = r % 20;
    n10 = r / 10; r = r % 10;
    n5  = r / 5;  r = r % 5;
    repeat (n20) exp_coins.push_back(20);
    repeat (n10) exp_coins.push_back(10);
    repeat (n5)  exp_coins.push_back(5);
    exp_short = (r != 0);
  endtask

  // Drives one sale and records what the DUT offered; k counts edges after sold.
  task automatic run_sale(input int c, input int hold_n, input bit rnd, input bit poke_sold);
    int  held;
    bit  poked;
    obs_coins.delete();
    obs_offers.delete();
    obs_wait = 0; obs_done = -1; obs_bad = 0; held = 0; poked = 0;
    @(negedge clk);
    credit = 6'(c); sold = 1'b1; coin_ack = 1'b0;
    @(negedge clk);
    sold = 1'b0; credit = 6'($urandom);
    for (int k = 1; k < 100; k++) begin
      if (done) begin
        obs_done = k;
        break;
      end
      if (!coin_valid && coin_out != 5'd0) obs_bad++;
      if (coin_valid) begin
        obs_offers.push_back(int'(coin_out));
        if (held < hold_n) begin
          coin_ack = 1'b0; held++; obs_wait++;
        end else if (rnd && $urandom_range(0, 2) == 0) begin
          coin_ack = 1'b0; obs_wait++;
        end else begin
          coin_ack = 1'b1;
          obs_coins.push_back(int'(coin_out));
        end
        if (poke_sold && !poked) begin
          sold = 1'b1; credit = 6'd0; poked = 1;
        end else begin
          sold = 1'b0;
        end
      end else begin
        coin_ack = 1'($urandom_range(0, 1));
        sold = 1'b0;
      end
      @(negedge clk);
    end
    sold = 1'b0; coin_ack = 1'b0;
    @(negedge clk);
    obs_done_after = int'(done) + 2 * int'(busy);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({coin_valid, busy, done, refund, short, coin_out, coin_count} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b busy=%b done=%b refund=%b short=%b coin=%0d cnt=%0d required all 0",
               coin_valid, busy, done, refund, short, coin_out, coin_count);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_change_45();
    run_sale(45, 0, 0, 0);
    checks++;
    if (obs_coins.size() != 1 || obs_coins[0] != 5) begin
      errors++; $display("FAIL c45_coins: got %p required '{5}", obs_coins);
    end
    checks++;
    if (obs_done != 3) begin errors++; $display("FAIL c45_done_cycle: got %0d required 3", obs_done); end
    checks++;
    if ({coin_count, refund, short} !== {4'd1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL c45_flags: got cnt=%0d refund=%b short=%b required 1/0/0", coin_count, refund, short);
    end
    checks++;
    if (obs_done_after != 0) begin errors++; $display("FAIL c45_after_done: got done+2*busy=%0d required 0", obs_done_after); end
  endtask

  task automatic test_exact_40();
    run_sale(40, 0, 0, 0);
    checks++;
    if (obs_offers.size() != 0) begin errors++; $display("FAIL c40_no_offer: got %0d offers required 0", obs_offers.size()); end
    checks++;
    if (obs_done != 2) begin errors++; $display("FAIL c40_done_cycle: got %0d required 2", obs_done); end
    checks++;
    if ({coin_count, refund, short} !== {4'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL c40_flags: got cnt=%0d refund=%b short=%b required 0/0/0", coin_count, refund, short);
    end
  endtask

  task automatic test_refund_30();
    run_sale(30, 0, 0, 0);
    checks++;
    if (obs_coins.size() != 2 || obs_coins[0] != 20 || obs_coins[1] != 10) begin
      errors++; $display("FAIL c30_coins: got %p required '{20,10}", obs_coins);
    end
    checks++;
    if ({coin_count, refund, short} !== {4'd2, 1'b1, 1'b0}) begin
      errors++; $display("FAIL c30_flags: got cnt=%0d refund=%b short=%b required 2/1/0", coin_count, refund, short);
    end
    checks++;
    if (obs_done != 4) begin errors++; $display("FAIL c30_done_cycle: got %0d required 4", obs_done); end
  endtask

  task automatic test_max_63_hold();
    int bad;
    run_sale(63, 4, 0, 0);
    bad = 0;
    foreach (obs_offers[i]) if (obs_offers[i] != 20) bad++;
    checks++;
    if (obs_offers.size() != 5 || bad != 0) begin
      errors++; $display("FAIL c63_stable_offer: got %p required five 20s", obs_offers);
    end
    checks++;
    if ({coin_count, refund, short} !== {4'd1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL c63_flags: got cnt=%0d refund=%b short=%b required 1/0/1", coin_count, refund, short);
    end
    checks++;
    if (obs_done != 7) begin errors++; $display("FAIL c63_done_cycle: got %0d required 7", obs_done); end
  endtask

  task automatic test_zero();
    run_sale(0, 0, 0, 0);
    checks++;
    if (obs_offers.size() != 0 || obs_done != 2) begin
      errors++; $display("FAIL c0_payout: got offers=%0d done_cycle=%0d required 0/2", obs_offers.size(), obs_done);
    end
    checks++;
    if ({coin_count, refund, short} !== {4'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL c0_flags: got cnt=%0d refund=%b short=%b required 0/1/0", coin_count, refund, short);
    end
  endtask

  task automatic test_sold_while_busy();
    int busy_seen;
    run_sale(55, 0, 0, 1);
    checks++;
    if (obs_coins.size() != 2 || obs_coins[0] != 10 || obs_coins[1] != 5) begin
      errors++; $display("FAIL busy_sold_coins: got %p required '{10,5}", obs_coins);
    end
    checks++;
    if ({coin_count, refund, short} !== {4'd2, 1'b0, 1'b0}) begin
      errors++; $display("FAIL busy_sold_flags: got cnt=%0d refund=%b short=%b required 2/0/0", coin_count, refund, short);
    end
    busy_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin errors++; $display("FAIL busy_sold_no_recalc: got %0d busy cycles required 0", busy_seen); end
  endtask

  task automatic test_random();
    int exp_done, mism;
    for (int it = 0; it < 25; it++) begin
      int c;
      c = $urandom_range(0, 63);
      model(c);
      run_sale(c, $urandom_range(0, 2), 1, 0);
      mism = (obs_coins.size() != exp_coins.size()) ? 1 : 0;
      if (mism == 0) foreach (exp_coins[i]) if (obs_coins[i] != exp_coins[i]) mism = 1;
      checks++;
      if (mism != 0) begin
        errors++; $display("FAIL rand_coins credit=%0d: got %p required %p", c, obs_coins, exp_coins);
      end
      checks++;
      if ({refund, short, coin_count} !== {exp_refund, exp_short, 4'(exp_coins.size())}) begin
        errors++;
        $display("FAIL rand_flags credit=%0d: got refund=%b short=%b cnt=%0d required %b/%b/%0d",
                 c, refund, short, coin_count, exp_refund, exp_short, exp_coins.size());
      end
      exp_done = (exp_coins.size() == 0) ? 2 : 2 + exp_coins.size() + obs_wait;
      checks++;
      if (obs_done != exp_done || obs_bad != 0) begin
        errors++;
        $display("FAIL rand_timing credit=%0d: got done_cycle=%0d stray_coin=%0d required %0d/0", c, obs_done, obs_bad, exp_done);
      end
    end
  endtask

  task automatic test_async_reset();
    int busy_seen;
    @(negedge clk);
    credit = 6'd30; sold = 1'b1; coin_ack = 1'b0;
    @(negedge clk);
    sold = 1'b0;
    @(negedge clk);
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({coin_valid, coin_out, coin_count, refund} !== {1'b1, 5'd10, 4'd1, 1'b1}) begin
      errors++;
      $display("FAIL arst_pre: got valid=%b coin=%0d cnt=%0d refund=%b required 1/10/1/1", coin_valid, coin_out, coin_count, refund);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({coin_valid, busy, done, refund, short, coin_out, coin_count} !== 14'd0) begin
      errors++;
      $display("FAIL arst_immediate: got valid=%b busy=%b done=%b refund=%b short=%b coin=%0d cnt=%0d required all 0",
               coin_valid, busy, done, refund, short, coin_out, coin_count);
    end
    @(negedge clk);
    reset = 1'b1;
    busy_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || coin_valid) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin errors++; $display("FAIL arst_stays_idle: got %0d active cycles required 0", busy_seen); end
    run_sale(45, 0, 0, 0);
    checks++;
    if (obs_coins.size() != 1 || obs_coins[0] != 5 || coin_count !== 4'd1) begin
      errors++; $display("FAIL arst_resume: got coins=%p cnt=%0d required '{5}/1", obs_coins, coin_count);
    end
  endtask

  initial begin
    test_reset();
    test_change_45();
    test_exact_40();
    test_refund_30();
    test_max_63_hold();
    test_zero();
    test_sold_while_busy();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Downstream stage of the vending FSM. When a sale completes, the block captures the accumulated credit balance and computes the change, or the full refund if the credit is short. It then pays that amount out one coin at a time using greedy 20/10/5 selection. Each coin is offered on a valid/ack handshake to the coin-ejector driver. The block sits between the vending FSM's sale pulse and credit register and the physical coin output.

Parameters:
PRICE, 40, product price in coin units; compared against captured credit.
CREDIT_W, 6, width of credit and remaining-change datapath.
COIN_W, 5, width of coin value bus (matches the coin bus into the vending FSM).
CNT_W, 4, width of dispensed-coin counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
sold  input  1  sale-complete indication from the vending FSM; sampled only in IDLE.
credit  input  CREDIT_W  accumulated balance; captured on the edge where sold=1 in IDLE.
coin_out  output  COIN_W  value of the coin currently offered (20, 10 or 5); 0 when coin_valid=0.
coin_valid  output  1  coin offer present.
coin_ack  input  1  ejector accepted the offered coin; meaningful only while coin_valid=1.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse at end of payout.
refund  output  1  registered; set when captured credit < PRICE; held until next capture.
short  output  1  registered; set when the final residue (1..4) cannot be paid in coins; held until next capture.
coin_count  output  CNT_W  coins dispensed in the current or last payout; saturates at all-ones.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low (port `reset`).
- Reset values (any state, including mid-payout): state=IDLE; all outputs 0; internal credit and remaining registers 0. Any in-flight payout is abandoned.
- States:
  - IDLE: if sold=1, latch credit into cap, clear refund, short and coin_count, then go to CALC. Otherwise stay.
  - CALC: if cap >= PRICE, rem <= cap - PRICE and refund <= 0. Otherwise rem <= cap and refund <= 1. Then go to OFFER if the new rem >= 5, else go to DONE.
  - OFFER: coin_valid=1. coin_out = 20 if rem >= 20, else 10 if rem >= 10, else 5. coin_out is combinational from registered rem, so it is stable while waiting.
    - On an edge with coin_ack=1: rem <= rem - coin_out and coin_count <= coin_count + 1 (saturating). If the new rem < 5, go to DONE; else stay in OFFER.
    - On an edge with coin_ack=0: hold rem and coin_out indefinitely.
  - DONE: done=1 for exactly this cycle; short <= (rem != 0); then go to IDLE.
- Latency:
  - Exact-price sale: sold edge, then CALC edge, then DONE. done is high 2 cycles after sold is sampled.
  - First coin_valid appears the cycle after CALC.
  - With ack tied high, each coin takes 1 cycle.
- Edge cases:
  - sold while busy is ignored; no queuing.
  - coin_ack while coin_valid=0 is ignored.
  - Arithmetic is unsigned CREDIT_W. The subtraction occurs only when cap >= PRICE, so there is no underflow.
  - Maximum credit 63 gives rem 23, paid as 20 with residue 3, so short=1.
  - Zero credit with sold gives refund=1, no coins, done after 2 cycles.
- busy = (state != IDLE). refund, short and coin_count stay readable in IDLE until the next capture.

Decomposition:
- Shared package holds:
  - PRICE default;
  - coin constants COIN_20, COIN_10, COIN_5;
  - the 3-bit state encoding IDLE=0, CALC=1, OFFER=2, DONE=3;
  - CREDIT_W and COIN_W.
- One sub-module, change_coin_select: combinational greedy selector with rem in and coin value out. It is reusable by a future coin-validator stage.
- The cap and rem registers reuse the team's existing 6-bit enable register (async active-low clear).

Test Plan:
- credit=45, sold pulse, coin_ack tied 1 -> one coin 5. coin_count=1, refund=0, short=0. done pulse 3 cycles after sold.
- credit=40, sold -> no coin_valid at any cycle. done 2 cycles after sold. coin_count=0.
- credit=30 (< PRICE), sold, ack tied 1 -> coins 20 then 10, refund=1, coin_count=2, short=0.
- credit=63, sold, ack held low 4 cycles then high -> coin_out=20 stable with coin_valid=1 for all 5 cycles. Then done, short=1, coin_count=1.
- Second sold pulse during OFFER -> ignored: payout of the first credit completes unchanged, and there is no second CALC.
- reset driven low mid-OFFER (asynchronously, between edges) -> coin_valid, busy, coin_out, counters and flags go to 0 immediately. After release, the block sits in IDLE until the next sold.
